// File: rtl/store_unit.sv
// Store path between the core and a word-wide synchronous data RAM.
// Handles sw directly and sb/sh by read-modify-write; rejects misaligned or illegal stores.
module store_unit #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [2:0] F_SB = 3'b000;
    localparam logic [2:0] F_SH = 3'b001;
    localparam logic [2:0] F_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_funct3;
    logic [1:0]            r_lane;
    logic [15:0]           r_data;
    logic                  r_err_q;
    logic                  r_done;
    logic                  r_err;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic                  w_req_err;
    logic                  w_unused_addr_hi;

    // The RAM is word-addressed; address bits above the RAM depth are deliberately ignored.
    assign w_unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    function automatic logic f_is_err(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F_SB:    return 1'b0;
            F_SH:    return lo[0];
            F_SW:    return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Little-endian lane replacement; bits outside the stored lane keep their RAM value.
    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [15:0] data,
                                            input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] w;
        w = old;
        if (f3 == F_SH) begin
            if (lane[1]) w[31:16] = data;
            else         w[15:0]  = data;
        end else begin
            case (lane)
                2'd0: w[7:0]   = data[7:0];
                2'd1: w[15:8]  = data[7:0];
                2'd2: w[23:16] = data[7:0];
                2'd3: w[31:24] = data[7:0];
                default: w = old;
            endcase
        end
        return w;
    endfunction

    assign w_req_err = f_is_err(funct3, addr[1:0]);

    // The core must freeze in the very cycle it raises req, hence the combinational IDLE term.
    assign stall     = (r_state == S_IDLE) ? req : (r_state != S_DONE);
    assign done      = r_done;
    assign err       = r_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_data      <= 16'h0000;
            r_err_q     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_funct3   <= funct3;
                        r_lane     <= addr[1:0];
                        r_data     <= store_data[15:0];
                        r_err_q    <= w_req_err;
                        r_mem_addr <= addr[ADDR_WIDTH+1:2];
                        if (w_req_err) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (funct3 == F_SW) begin
                            r_state     <= S_WRITE;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= store_data;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_MERGE;
                end
                S_MERGE: begin
                    r_mem_wdata <= f_merge(mem_rdata, r_data, r_funct3, r_lane);
                    r_mem_we    <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_done  <= 1'b1;
                    r_err   <= r_err_q;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: a synchronous RAM model plus a byte-level reference memory
// predicting the RAM content, latency and error response of each store.
module tb_store_unit;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              req;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       store_data;
    logic              stall;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] ram     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    logic              pre_en;
    logic [ADDR_W-1:0] pre_idx;
    logic [31:0]       pre_val;

    int checks;
    int failures;
    int we_total;

    store_unit #(.ADDR_WIDTH(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data registered one cycle after the address; preload port for the bench.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_total      <= we_total + 1;
        end else if (pre_en) begin
            ram[pre_idx] <= pre_val;
        end
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preset(input int idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_en  = 1'b1;
        pre_idx = idx[ADDR_W-1:0];
        pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Expected RAM word after a legal store, from byte-lane arithmetic.
    function automatic logic [31:0] model_word(input logic [31:0] old, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (f3 == 3'b010) return d;
        if (f3 == 3'b001) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            return (old & ~mask) | ((d & 32'h0000_FFFF) << sh);
        end
        sh   = 8 * int'(a[1:0]);
        mask = 32'h0000_00FF << sh;
        return (old & ~mask) | ((d & 32'h0000_00FF) << sh);
    endfunction

    function automatic logic model_legal(input logic [2:0] f3, input logic [31:0] a);
        return (f3 == 3'b000) || (f3 == 3'b001 && a[0] == 1'b0) || (f3 == 3'b010 && a[1:0] == 2'b00);
    endfunction

    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input string nm);
        logic              legal;
        int                exp_lat;
        int                widx;
        logic [31:0]       exp_w;
        int                done_at;
        int                we_cnt;
        int                we_at;
        logic [31:0]       wd;
        logic [ADDR_W-1:0] wa;
        logic              got_err;
        logic              stall_ok;

        legal   = model_legal(f3, a);
        exp_lat = !legal ? 1 : (f3 == 3'b010 ? 2 : 4);
        widx    = int'(a[ADDR_W+1:2]);
        exp_w   = model_word(ref_mem[widx], f3, a, d);
        done_at = 0; we_cnt = 0; we_at = 0; wd = '0; wa = '0; got_err = 1'b0; stall_ok = 1'b1;

        @(posedge clk); #1;
        req = 1'b1; funct3 = f3; addr = a; store_data = d;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL %s stall_T0: got %b expected 1", nm, stall);
        end
        for (int k = 1; k <= 8 && done_at == 0; k++) begin
            @(posedge clk); #1;
            req = 1'b0;
            @(negedge clk);
            if (mem_we === 1'b1) begin
                we_cnt++; we_at = k; wd = mem_wdata; wa = mem_addr;
            end
            if (done === 1'b1) begin
                done_at = k; got_err = err;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end

        checks++;
        if (done_at != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", nm, done_at, exp_lat);
        end
        checks++;
        if (got_err !== !legal) begin
            failures++;
            $display("FAIL %s err: got %b expected %b", nm, got_err, !legal);
        end
        checks++;
        if (we_cnt != (legal ? 1 : 0)) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", nm, we_cnt, legal ? 1 : 0);
        end
        checks++;
        if (!stall_ok) begin
            failures++;
            $display("FAIL %s stall_profile: got irregular expected high until done", nm);
        end
        if (legal) begin
            checks++;
            if (we_at != exp_lat - 1) begin
                failures++;
                $display("FAIL %s write_cycle: got %0d expected %0d", nm, we_at, exp_lat - 1);
            end
            checks++;
            if (int'(wa) != widx) begin
                failures++;
                $display("FAIL %s mem_addr: got %h expected %h", nm, wa, widx);
            end
            checks++;
            if (wd !== exp_w) begin
                failures++;
                $display("FAIL %s mem_wdata: got %h expected %h", nm, wd, exp_w);
            end
            ref_mem[widx] = exp_w;
        end
        checks++;
        if (ram[widx] !== ref_mem[widx]) begin
            failures++;
            $display("FAIL %s ram_word: got %h expected %h", nm, ram[widx], ref_mem[widx]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b0; funct3 = 3'b000; addr = '0; store_data = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0; we_total = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, done, err, mem_we, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got %b%b%b%b %h %h expected all zero",
                     stall, done, err, mem_we, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall, done, err, mem_we, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_release: got %b%b%b%b %h %h expected all zero",
                     stall, done, err, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_directed;
        preset(16'h10, 32'h0000_0000);
        run_store(3'b010, 32'h0000_0040, 32'hDEAD_BEEF, "sw_0x40");
        preset(16'h10, 32'h1122_3344);
        run_store(3'b000, 32'h0000_0043, 32'h0000_00AB, "sb_lane3");
        preset(16'h10, 32'h1122_3344);
        run_store(3'b001, 32'h0000_0042, 32'hFFFF_5566, "sh_upper");
        run_store(3'b000, 32'h0000_0040, 32'h0000_0077, "sb_lane0_after_sh");
        checks++;
        if (ram[16'h10] !== 32'h5566_3377) begin
            failures++;
            $display("FAIL sh_sb_combined: got %h expected 55663377", ram[16'h10]);
        end
    endtask

    task automatic test_errors;
        run_store(3'b001, 32'h0000_0041, 32'h1234_5678, "sh_misaligned");
        run_store(3'b010, 32'h0000_0042, 32'h1234_5678, "sw_misaligned");
        run_store(3'b011, 32'h0000_0040, 32'h1234_5678, "illegal_011");
        run_store(3'b111, 32'h0000_0044, 32'h1234_5678, "illegal_111");
    endtask

    task automatic test_back_to_back;
        run_store(3'b010, 32'h0000_0048, 32'hA5A5_0001, "b2b_sw");
        run_store(3'b000, 32'h0000_0049, 32'h0000_003C, "b2b_sb");
        run_store(3'b001, 32'h0000_0044, 32'h0000_BEEF, "b2b_sh");
        run_store(3'b010, 32'h0000_0045, 32'h0, "b2b_bad");
        run_store(3'b010, 32'h0000_004C, 32'h0BAD_F00D, "b2b_sw2");
    endtask

    task automatic test_busy;
        logic [8:0]        we_k, done_k, stall_k;
        logic [31:0]       wd_k [0:8];
        logic [ADDR_W-1:0] wa_k [0:8];
        logic [8:0]        exp_we, exp_done, exp_stall;
        logic [31:0]       exp_sb, exp_sw;
        exp_we    = 9'b001001000;
        exp_done  = 9'b010010000;
        exp_stall = 9'b001101111;
        preset(16'h10, 32'hA1B2_C3D4);
        preset(16'h11, 32'h0101_0101);
        preset(16'h12, 32'h0202_0202);
        exp_sb = model_word(ref_mem[16'h10], 3'b000, 32'h40, 32'h99);
        exp_sw = 32'hCAFE_F00D;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            case (k)
                0: begin req = 1'b1; funct3 = 3'b000; addr = 32'h40; store_data = 32'h99; end
                2: begin req = 1'b1; funct3 = 3'b010; addr = 32'h44; store_data = 32'h1234_5678; end
                4, 5: begin req = 1'b1; funct3 = 3'b010; addr = 32'h48; store_data = exp_sw; end
                default: req = 1'b0;
            endcase
            @(negedge clk);
            we_k[k] = mem_we; done_k[k] = done; stall_k[k] = stall;
            wd_k[k] = mem_wdata; wa_k[k] = mem_addr;
        end
        req = 1'b0;
        checks++;
        if (we_k !== exp_we) begin
            failures++;
            $display("FAIL busy_we_cycles: got %b expected %b", we_k, exp_we);
        end
        checks++;
        if (done_k !== exp_done) begin
            failures++;
            $display("FAIL busy_done_cycles: got %b expected %b", done_k, exp_done);
        end
        checks++;
        if (stall_k !== exp_stall) begin
            failures++;
            $display("FAIL busy_stall_cycles: got %b expected %b", stall_k, exp_stall);
        end
        checks++;
        if (wd_k[3] !== exp_sb || wa_k[3] !== 14'h10) begin
            failures++;
            $display("FAIL busy_sb_write: got %h@%h expected %h@10", wd_k[3], wa_k[3], exp_sb);
        end
        checks++;
        if (wd_k[6] !== exp_sw || wa_k[6] !== 14'h12) begin
            failures++;
            $display("FAIL busy_reissued_sw: got %h@%h expected %h@12", wd_k[6], wa_k[6], exp_sw);
        end
        ref_mem[16'h10] = exp_sb;
        ref_mem[16'h12] = exp_sw;
        checks++;
        if (ram[16'h10] !== ref_mem[16'h10] || ram[16'h11] !== ref_mem[16'h11] ||
            ram[16'h12] !== ref_mem[16'h12]) begin
            failures++;
            $display("FAIL busy_ram: got %h %h %h expected %h %h %h", ram[16'h10], ram[16'h11],
                     ram[16'h12], ref_mem[16'h10], ref_mem[16'h11], ref_mem[16'h12]);
        end
    endtask

    task automatic test_reset_mid;
        int we_before;
        preset(5, 32'h1122_3344);
        we_before = we_total;
        @(posedge clk); #1;
        req = 1'b1; funct3 = 3'b000; addr = 32'h15; store_data = 32'hEE;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, done, err, mem_we, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b%b%b%b %h %h expected all zero",
                     stall, done, err, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (we_total != we_before || ram[5] !== 32'h1122_3344) begin
            failures++;
            $display("FAIL reset_mid_ram: got writes=%0d word=%h expected writes=%0d word=11223344",
                     we_total - we_before, ram[5], 0);
        end
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: got stall=%b done=%b expected 0 0", stall, done);
        end
        run_store(3'b010, 32'h0000_0014, 32'h600D_CAFE, "sw_after_reset");
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < 16; i++) preset(i, $urandom);
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            f3 = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
            a  = ($urandom << 16) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == 3'b001) a[0] = 1'b0;
                if (f3 == 3'b010) a[1:0] = 2'b00;
            end
            run_store(f3, a, $urandom, "random");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Multi-cycle store path between the CPU core and the word-wide synchronous data RAM.
- Implements sw, sh and sb. The RAM accepts only full-word writes, so sub-word stores use read-modify-write.
- It is the writer-side counterpart of the load byte-extraction path that sits in front of the register file.
- Stalls the core for the duration of each store and flags misaligned or illegal stores.

Parameters:
- ADDR_WIDTH, 14, word-address width of the data RAM (RAM depth is 2^ADDR_WIDTH words).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  store request from the core, qualified by the S-type opcode.
- funct3  input  3  store width: 000 = sb, 001 = sh, 010 = sw.
- addr  input  32  byte address (ALU result).
- store_data  input  32  rs2 value.
- stall  output  1  holds the PC and instruction while the store is in progress.
- done  output  1  one-cycle pulse when the store completes or is rejected.
- err  output  1  one-cycle pulse, coincident with done, for a misaligned or illegal store.
- mem_addr  output  ADDR_WIDTH  RAM word address.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid one cycle after mem_addr is sampled.

Behaviour:
- States: IDLE, READ, MERGE, WRITE, DONE.
- Reset (async, immediate): state = IDLE; stall, done, err, mem_we = 0; mem_addr = 0; mem_wdata = 0; latched request registers cleared.
- IDLE
  - stall = req (combinational), so the core freezes in the request cycle.
  - On req: latch addr, funct3 and store_data, and set err_q from the checks below.
  - Transitions: err_q set -> DONE; sw -> WRITE; sb/sh -> READ.
- Error checks (any one sets err_q):
  - funct3 not in {000, 001, 010} (illegal).
  - sh with addr[0] = 1 (misaligned).
  - sw with addr[1:0] != 00 (misaligned).
- mem_addr = latched addr[ADDR_WIDTH+1:2]; upper address bits are ignored (no wrap check).
- READ: mem_we = 0; mem_addr presented; go to MERGE.
- MERGE
  - mem_rdata is valid in this cycle; register the merged word.
  - Little-endian lane replacement, all other bits kept from mem_rdata:
    - sb: byte lane addr[1:0] <- store_data[7:0].
    - sh: half lane addr[1] <- store_data[15:0].
  - Go to WRITE.
- WRITE
  - mem_we = 1 for exactly one cycle.
  - mem_wdata = merged word (sb/sh) or latched store_data (sw).
  - Go to DONE.
- DONE
  - done = 1; err = err_q; mem_we = 0; stall = 0, so the core advances on this edge.
  - Go to IDLE.
- stall = 1 in READ, MERGE and WRITE.
- Latency from the req cycle T0 to the done pulse:
  - sw: T2.
  - sb/sh: T4.
  - rejected store: T1, with no RAM write at any point.
- req while not in IDLE is ignored; the latched registers are not overwritten.
- req asserted in the same cycle as the DONE pulse is ignored; it is accepted in the following IDLE cycle, because the core re-presents it.
- Reset asserted mid-operation (READ/MERGE/WRITE): no write is issued and mem_we drops immediately. A partially read word is discarded, so RAM content is unchanged.
- Back-to-back stores: the next req is accepted in the IDLE cycle after DONE; there is no extra bubble.

Test Plan:
- sw: RAM[0x10] = 0, req addr = 0x40, data = 0xDEADBEEF -> mem_we at T1 with wdata 0xDEADBEEF, mem_addr 0x10, done at T2, RAM[0x10] = 0xDEADBEEF.
- sb lane 3: RAM[0x10] = 0x11223344, addr = 0x43, data = 0x000000AB -> write at T3 of 0xAB223344, done at T4, stall high T0–T3.
- sh upper half: RAM[0x10] = 0x11223344, addr = 0x42, data = 0xFFFF5566 -> RAM[0x10] = 0x55663344; a subsequent sb to addr 0x40 with data 0x77 gives 0x55663377.
- Misaligned/illegal:
  - sh addr = 0x41 -> done and err at T1, mem_we never asserted.
  - sw addr = 0x42 -> same response.
  - funct3 = 011 -> same response.
- Request during busy: sb issued, then req pulsed in MERGE with sw data 0x12345678 -> ignored; only the sb merge is written.
- Reset mid-store: reset low during MERGE of an sb -> outputs zero immediately, state IDLE, RAM word unchanged.
